cp0_exception_unit: RTL and testbench
=====================================

Name: cp0_exception_unit

Overview:
- MEM-stage exception resolver plus CP0 register file for the MIPS pipeline.
- Prioritises exception flags carried down from IF/ID/EX/MEM, samples interrupts and handles ERET.
- Drives is_exp into the MEM-stage flush mux that suppresses mem/reg/hi/lo/cp0 writes, and supplies the flush redirect PC.
- Owns Status, Cause, EPC, BadVAddr, Count and Compare, with their update sequencing.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect PC for every exception and interrupt.
- COUNT_DIV, 2, clock cycles per Count increment (must be ≥1).

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- mem_valid  in  1  MEM stage holds a real instruction (not a bubble)
- mem_pc  in  32  PC of the MEM instruction
- mem_in_ds  in  1  MEM instruction is in a branch delay slot
- exc_adel_if  in  1  fetch address error; the bad address is mem_pc
- exc_ri  in  1  reserved instruction
- exc_ov  in  1  arithmetic overflow
- exc_sys  in  1  syscall
- exc_bp  in  1  break
- exc_adel_d  in  1  load address error
- exc_ades  in  1  store address error
- mem_daddr  in  32  data address, for BadVAddr
- mem_eret  in  1  MEM instruction is ERET
- hw_int  in  6  external interrupt lines, level-sensitive
- cp0_we  in  1  MTC0 write enable (pre-flush)
- cp0_waddr  in  5  MTC0 register number
- cp0_wdata  in  32  MTC0 data
- cp0_raddr  in  5  MFC0 register number
- cp0_rdata  out  32  MFC0 read data, combinational
- is_exp  out  1  exception or interrupt taken this cycle
- flush  out  1  is_exp OR ERET taken
- flush_pc  out  32  EXC_VECTOR when is_exp, else EPC
- cause_out, status_out, epc_out  out  32 each  live register values

Behaviour:
- Reset (asynchronous, resetn=0):
  - Status = 32'h0040_0000 (BEV=1, IM=0, EXL=0, IE=0).
  - Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0, divider = 0.
  - All flush outputs are 0.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- Cause.IP[7:2] takes hw_int every cycle, with IP[7] = hw_int[5] | Cause.TI. IP[1:0] is writable by MTC0 only.
- Exception selection is combinational, valid only when mem_valid = 1. Priority, high to low, with ExcCode:
  - interrupt 0x00
  - exc_adel_if 0x04
  - exc_ri 0x0A
  - exc_ov 0x0C
  - exc_sys 0x08
  - exc_bp 0x09
  - exc_adel_d 0x04
  - exc_ades 0x05
- is_exp = mem_valid & (int_pending | any flag). It is asserted in the same cycle; CP0 updates at the next rising edge.
- On the taken edge:
  - Status.EXL ← 1.
  - Cause.ExcCode ← selected code.
  - Cause.BD ← mem_in_ds.
  - EPC ← mem_in_ds ? mem_pc − 4 : mem_pc.
  - EPC and BD are not updated if Status.EXL was already 1.
  - BadVAddr ← mem_pc for AdEL-fetch, mem_daddr for AdEL-data or AdES; unchanged otherwise.
- ERET (mem_valid & mem_eret & ~is_exp):
  - flush = 1, flush_pc = EPC.
  - Status.EXL ← 0 at the edge.
  - An ERET carrying its own exception flag is treated as the exception.
- MTC0 is applied at the edge only if cp0_we & ~is_exp; an exception in the same cycle suppresses the write. Writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - EPC, Compare, Count: full 32 bits.
  - BadVAddr: read-only.
- Timer:
  - The divider counts 0..COUNT_DIV−1; Count increments when the divider wraps. Count wraps from 32'hFFFF_FFFF to 0.
  - An MTC0 write to Count wins over a same-cycle increment, and the divider is not reset.
  - Cause.TI is set at the edge where Count (new value) == Compare and Compare ≠ 0.
  - An MTC0 write to Compare clears TI; the clear wins over a same-cycle set.
- cp0_rdata shows registered values (no MTC0 bypass). Unimplemented register numbers read 0.
- Mid-operation reset clears all state immediately; flush drops asynchronously.

Decomposition:
- Shared package cp0_defs holds:
  - CP0 register numbers (8, 9, 11, 12, 13, 14).
  - ExcCode constants.
  - Status/Cause bit positions: IE 0, EXL 1, IM 15:8, IP 15:8, ExcCode 6:2, TI 30, BD 31.
  - EXC_VECTOR default.
- One sub-module, cp0_timer, holds Count, Compare, the divider and TI generation.

Test Plan:
- exc_ov=1, mem_pc=32'h8000_1000, mem_in_ds=0, mem_valid=1 → is_exp=1, flush_pc=32'hBFC0_0380; after the edge EPC=32'h8000_1000, ExcCode=0x0C, EXL=1, BD=0.
- exc_ades=1, mem_daddr=32'h8000_0003, mem_in_ds=1, mem_pc=32'h8000_2004 → EPC=32'h8000_2000, BD=1, BadVAddr=32'h8000_0003, ExcCode=0x05.
- exc_ri=1 and exc_sys=1 together with cp0_we=1 to EPC → ExcCode=0x0A; the MTC0 write is dropped.
- Status=32'h0040_8001, hw_int[5]=1, mem_valid=1 → interrupt taken with ExcCode=0x00; with EXL=1 instead → is_exp=0.
- Compare=5, COUNT_DIV=2, from reset → TI=1 once Count becomes 5 (edge 10); MTC0 Compare=9 clears TI.
- Exception with EXL=1, then ERET with mem_eret=1 → flush=1, flush_pc=EPC, EXL=0; a second exception while EXL=1 leaves EPC unchanged.

Source files
------------

// File: rtl/cp0_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_defs : shared CP0 register numbers, ExcCodes and field positions  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cp0_defs;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int ST_IM_LO   = 8;
    localparam int ST_IM_HI   = 15;
    localparam int CA_IP_LO   = 8;
    localparam int CA_IP_HI   = 15;
    localparam int CA_EXC_LO  = 2;
    localparam int CA_EXC_HI  = 6;
    localparam int CA_TI      = 30;
    localparam int CA_BD      = 31;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    // Flag vector bit order, highest priority first after the interrupt.
    localparam int FLG_ADEL_IF = 6;
    localparam int FLG_RI      = 5;
    localparam int FLG_OV      = 4;
    localparam int FLG_SYS     = 3;
    localparam int FLG_BP      = 2;
    localparam int FLG_ADEL_D  = 1;
    localparam int FLG_ADES    = 0;

    typedef enum logic [1:0] {
        BAD_KEEP  = 2'd0,
        BAD_PC    = 2'd1,
        BAD_DADDR = 2'd2
    } badv_src_e;

    typedef struct packed {
        logic [4:0] code;
        badv_src_e  badv;
    } exc_sel_t;

    function automatic exc_sel_t sel_exc(input logic irq, input logic [6:0] flags);
        exc_sel_t s;
        s.code = EXC_INT;
        s.badv = BAD_KEEP;
        if (irq)                     s.code = EXC_INT;
        else if (flags[FLG_ADEL_IF]) begin s.code = EXC_ADEL; s.badv = BAD_PC;    end
        else if (flags[FLG_RI])      s.code = EXC_RI;
        else if (flags[FLG_OV])      s.code = EXC_OV;
        else if (flags[FLG_SYS])     s.code = EXC_SYS;
        else if (flags[FLG_BP])      s.code = EXC_BP;
        else if (flags[FLG_ADEL_D])  begin s.code = EXC_ADEL; s.badv = BAD_DADDR; end
        else if (flags[FLG_ADES])    begin s.code = EXC_ADES; s.badv = BAD_DADDR; end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_timer : Count/Compare pair with clock divider and TI generation  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_we_count,
    input  logic        i_we_compare,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [31:0]      r_count;
    logic [31:0]      r_compare;
    logic             r_ti;
    logic             w_tick;
    logic [31:0]      w_count_nxt;

    assign w_tick = (r_div == DIV_LAST);

    // A software write to Count overrides the increment but leaves the divider phase alone.
    always_comb begin
        w_count_nxt = r_count;
        if (i_we_count)
            w_count_nxt = i_wdata;
        else if (w_tick)
            w_count_nxt = r_count + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div     <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_div   <= w_tick ? '0 : r_div + DIV_W'(1);
            r_count <= w_count_nxt;
            if (i_we_compare)
                r_compare <= i_wdata;
            if (i_we_compare)
                r_ti <= 1'b0;
            else if ((w_count_nxt == r_compare) && (r_compare != 32'd0))
                r_ti <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_exception_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_exception_unit : MEM-stage exception resolver and CP0 registers  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cp0_exception_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_ds,
    input  logic        exc_adel_if,
    input  logic        exc_ri,
    input  logic        exc_ov,
    input  logic        exc_sys,
    input  logic        exc_bp,
    input  logic        exc_adel_d,
    input  logic        exc_ades,
    input  logic [31:0] mem_daddr,
    input  logic        mem_eret,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        is_exp,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic [31:0] cause_out,
    output logic [31:0] status_out,
    output logic [31:0] epc_out
);

    logic [ST_IM_HI:ST_IM_LO] r_im;
    logic                     r_exl;
    logic                     r_ie;
    logic                     r_bd;
    logic [4:0]               r_code;
    logic [5:0]               r_hw_ip;
    logic [1:0]               r_sw_ip;
    logic [31:0]              r_epc;
    logic [31:0]              r_badvaddr;

    logic [6:0]  w_flags;
    logic [7:0]  w_ip;
    logic        w_ti;
    logic        w_int_pending;
    logic        w_exp;
    logic        w_eret;
    logic        w_wr;
    exc_sel_t    w_sel;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_count;
    logic [31:0] w_compare;

    assign w_flags = {exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades};
    assign w_ip    = {r_hw_ip[5] | w_ti, r_hw_ip[4:0], r_sw_ip};

    assign w_int_pending = r_ie & ~r_exl & (|(w_ip & r_im));
    assign w_sel         = sel_exc(w_int_pending, w_flags);

    // Gating with resetn makes the flush request drop the moment reset asserts.
    assign w_exp  = resetn & mem_valid & (w_int_pending | (|w_flags));
    assign w_eret = resetn & mem_valid & mem_eret & ~w_exp;
    assign w_wr   = cp0_we & ~w_exp;

    assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_code, 2'b00};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_im    <= '0;
            r_exl   <= 1'b0;
            r_ie    <= 1'b0;
            r_bd    <= 1'b0;
            r_code  <= '0;
            r_hw_ip <= '0;
            r_sw_ip <= '0;
            r_epc   <= '0;
        end else begin
            r_hw_ip <= hw_int;
            if (w_exp) begin
                r_exl  <= 1'b1;
                r_code <= w_sel.code;
                // A nested exception keeps the original return point.
                if (!r_exl) begin
                    r_bd  <= mem_in_ds;
                    r_epc <= mem_in_ds ? mem_pc - 32'd4 : mem_pc;
                end
            end else begin
                if (w_eret)
                    r_exl <= 1'b0;
                if (w_wr) begin
                    case (cp0_waddr)
                        CP0_STATUS: begin
                            r_im  <= cp0_wdata[ST_IM_HI:ST_IM_LO];
                            r_exl <= cp0_wdata[ST_EXL];
                            r_ie  <= cp0_wdata[ST_IE];
                        end
                        CP0_CAUSE: r_sw_ip <= cp0_wdata[CA_IP_LO+1:CA_IP_LO];
                        CP0_EPC:   r_epc   <= cp0_wdata;
                        default:   ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_badvaddr <= '0;
        end else if (w_exp) begin
            case (w_sel.badv)
                BAD_PC:    r_badvaddr <= mem_pc;
                BAD_DADDR: r_badvaddr <= mem_daddr;
                default:   ;
            endcase
        end
    end

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_we_count   (w_wr & (cp0_waddr == CP0_COUNT)),
        .i_we_compare (w_wr & (cp0_waddr == CP0_COMPARE)),
        .i_wdata      (cp0_wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = r_badvaddr;
            CP0_COUNT:    cp0_rdata = w_count;
            CP0_COMPARE:  cp0_rdata = w_compare;
            CP0_STATUS:   cp0_rdata = w_status;
            CP0_CAUSE:    cp0_rdata = w_cause;
            CP0_EPC:      cp0_rdata = r_epc;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign is_exp     = w_exp;
    assign flush      = w_exp | w_eret;
    assign flush_pc   = w_exp ? EXC_VECTOR : r_epc;
    assign cause_out  = w_cause;
    assign status_out = w_status;
    assign epc_out    = r_epc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cp0_exception_unit : vector table plus scoreboard for CP0 unit     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_cp0_exception_unit;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam logic [6:0] F_IF  = 7'b1000000;
    localparam logic [6:0] F_RI  = 7'b0100000;
    localparam logic [6:0] F_OV  = 7'b0010000;
    localparam logic [6:0] F_SYS = 7'b0001000;
    localparam logic [6:0] F_BP  = 7'b0000100;
    localparam logic [6:0] F_ADD = 7'b0000010;
    localparam logic [6:0] F_ADS = 7'b0000001;
    localparam logic [6:0] F_NO  = 7'b0000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_in_ds, mem_eret, cp0_we;
    logic        exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades;
    logic [31:0] mem_pc, mem_daddr, cp0_wdata;
    logic [5:0]  hw_int;
    logic [4:0]  cp0_waddr, cp0_raddr;
    logic [31:0] cp0_rdata, flush_pc, cause_out, status_out, epc_out;
    logic        is_exp, flush;

    cp0_exception_unit #(.EXC_VECTOR(VEC), .COUNT_DIV(2)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_in_ds(mem_in_ds), .exc_adel_if(exc_adel_if), .exc_ri(exc_ri),
        .exc_ov(exc_ov), .exc_sys(exc_sys), .exc_bp(exc_bp), .exc_adel_d(exc_adel_d),
        .exc_ades(exc_ades), .mem_daddr(mem_daddr), .mem_eret(mem_eret), .hw_int(hw_int),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .is_exp(is_exp), .flush(flush),
        .flush_pc(flush_pc), .cause_out(cause_out), .status_out(status_out), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic [6:0]  flags;
        logic [31:0] daddr;
        logic        eret;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        e_exp;
        logic        e_flush;
        logic [31:0] e_fpc;
        logic [31:0] e_epc;
        logic [4:0]  e_code;
        logic        e_bd;
        logic        e_exl;
        logic [31:0] e_bad;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[22];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_v(input string n, input logic [31:0] v);
        sb_q.push_back('{n, v});
    endtask

    task automatic got(input logic [31:0] act);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %h with nothing expected", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    endtask

    task automatic idle();
        mem_valid = 1'b0; mem_pc = 32'd0; mem_in_ds = 1'b0; mem_daddr = 32'd0;
        {exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades} = 7'd0;
        mem_eret = 1'b0; hw_int = 6'd0; cp0_we = 1'b0; cp0_waddr = 5'd0;
        cp0_wdata = 32'd0; cp0_raddr = 5'd8;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        idle();
        mem_valid = v.valid; mem_pc = v.pc; mem_in_ds = v.ds; mem_daddr = v.daddr;
        {exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades} = v.flags;
        mem_eret = v.eret; cp0_we = v.we; cp0_waddr = v.waddr; cp0_wdata = v.wdata;
        expect_v({v.name, ".is_exp"}, 32'(v.e_exp));
        expect_v({v.name, ".flush"}, 32'(v.e_flush));
        expect_v({v.name, ".flush_pc"}, v.e_fpc);
        #1;
        got(32'(is_exp)); got(32'(flush)); got(flush_pc);
        expect_v({v.name, ".epc"}, v.e_epc);
        expect_v({v.name, ".cause"}, (32'(v.e_bd) << 31) | (32'(v.e_code) << 2));
        expect_v({v.name, ".status"}, 32'h0040_0000 | (32'(v.e_exl) << 1));
        expect_v({v.name, ".badvaddr"}, v.e_bad);
        @(posedge clk); #1;
        got(epc_out); got(cause_out); got(status_out); got(cp0_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name          v  pc            ds flags             daddr         er we wa     wdata         x  f  fpc           epc           code   bd exl bad
        vecs[0]  = '{"bubble",    0, 32'h80000000, 0, F_OV,             32'h0,        0, 0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0,        5'h00, 0, 0, 32'h0};
        vecs[1]  = '{"ov",        1, 32'h80001000, 0, F_OV,             32'h0,        0, 0, 5'd0,  32'h0,        1, 1, VEC,          32'h80001000, 5'h0C, 0, 1, 32'h0};
        vecs[2]  = '{"eret1",     1, 32'h80001100, 0, F_NO,             32'h0,        1, 0, 5'd0,  32'h0,        0, 1, 32'h80001000, 32'h80001000, 5'h0C, 0, 0, 32'h0};
        vecs[3]  = '{"ades_ds",   1, 32'h80002004, 1, F_ADS,            32'h80000003, 0, 0, 5'd0,  32'h0,        1, 1, VEC,          32'h80002000, 5'h05, 1, 1, 32'h80000003};
        vecs[4]  = '{"eret2",     1, 32'h80002100, 0, F_NO,             32'h0,        1, 0, 5'd0,  32'h0,        0, 1, 32'h80002000, 32'h80002000, 5'h05, 1, 0, 32'h80000003};
        vecs[5]  = '{"ri_sys_wr", 1, 32'h80003000, 0, F_RI | F_SYS,     32'h0,        0, 1, 5'd14, 32'h12345678, 1, 1, VEC,          32'h80003000, 5'h0A, 0, 1, 32'h80000003};
        vecs[6]  = '{"bp_in_exl", 1, 32'h80004000, 1, F_BP,             32'h0,        0, 0, 5'd0,  32'h0,        1, 1, VEC,          32'h80003000, 5'h09, 0, 1, 32'h80000003};
        vecs[7]  = '{"eret_sys",  1, 32'h80005000, 0, F_SYS,            32'h0,        1, 0, 5'd0,  32'h0,        1, 1, VEC,          32'h80003000, 5'h08, 0, 1, 32'h80000003};
        vecs[8]  = '{"eret3",     1, 32'h80005004, 0, F_NO,             32'h0,        1, 0, 5'd0,  32'h0,        0, 1, 32'h80003000, 32'h80003000, 5'h08, 0, 0, 32'h80000003};
        vecs[9]  = '{"adel_if",   1, 32'h80006000, 0, F_IF|F_OV|F_ADD,  32'h11111111, 0, 0, 5'd0,  32'h0,        1, 1, VEC,          32'h80006000, 5'h04, 0, 1, 32'h80006000};
        vecs[10] = '{"eret4",     1, 32'h80006100, 0, F_NO,             32'h0,        1, 0, 5'd0,  32'h0,        0, 1, 32'h80006000, 32'h80006000, 5'h04, 0, 0, 32'h80006000};
        vecs[11] = '{"adel_d",    1, 32'h80007000, 0, F_ADD,            32'h80000011, 0, 0, 5'd0,  32'h0,        1, 1, VEC,          32'h80007000, 5'h04, 0, 1, 32'h80000011};
        vecs[12] = '{"eret5",     1, 32'h80007100, 0, F_NO,             32'h0,        1, 0, 5'd0,  32'h0,        0, 1, 32'h80007000, 32'h80007000, 5'h04, 0, 0, 32'h80000011};
        vecs[13] = '{"mtc0_epc",  1, 32'h80007200, 0, F_NO,             32'h0,        0, 1, 5'd14, 32'h8000ABC0, 0, 0, 32'h80007000, 32'h8000ABC0, 5'h04, 0, 0, 32'h80000011};
        vecs[14] = '{"eret6",     1, 32'h80007300, 0, F_NO,             32'h0,        1, 0, 5'd0,  32'h0,        0, 1, 32'h8000ABC0, 32'h8000ABC0, 5'h04, 0, 0, 32'h80000011};
        vecs[15] = '{"mtc0_badv", 1, 32'h80007400, 0, F_NO,             32'h0,        0, 1, 5'd8,  32'hDEADBEEF, 0, 0, 32'h8000ABC0, 32'h8000ABC0, 5'h04, 0, 0, 32'h80000011};
        vecs[16] = '{"ov_prio",   1, 32'h80008000, 0, F_OV|F_SYS|F_BP|F_ADS, 32'h22222222, 0, 0, 5'd0, 32'h0,    1, 1, VEC,          32'h80008000, 5'h0C, 0, 1, 32'h80000011};
        vecs[17] = '{"eret7",     1, 32'h80008100, 0, F_NO,             32'h0,        1, 0, 5'd0,  32'h0,        0, 1, 32'h80008000, 32'h80008000, 5'h0C, 0, 0, 32'h80000011};
        vecs[18] = '{"sys_bp",    1, 32'h80009000, 0, F_SYS | F_BP,     32'h0,        0, 0, 5'd0,  32'h0,        1, 1, VEC,          32'h80009000, 5'h08, 0, 1, 32'h80000011};
        vecs[19] = '{"eret8",     1, 32'h80009100, 0, F_NO,             32'h0,        1, 0, 5'd0,  32'h0,        0, 1, 32'h80009000, 32'h80009000, 5'h08, 0, 0, 32'h80000011};
        vecs[20] = '{"bp_adeld",  1, 32'h8000A000, 1, F_BP | F_ADD,     32'h33333333, 0, 0, 5'd0,  32'h0,        1, 1, VEC,          32'h80009FFC, 5'h09, 1, 1, 32'h80000011};
        vecs[21] = '{"eret9",     1, 32'h8000A100, 0, F_NO,             32'h0,        1, 0, 5'd0,  32'h0,        0, 1, 32'h80009FFC, 32'h80009FFC, 5'h09, 1, 0, 32'h80000011};

        // Reset state, with an excepting instruction held on the inputs.
        idle();
        resetn = 1'b0;
        mem_valid = 1'b1; exc_ov = 1'b1;
        expect_v("rst.is_exp", 32'd0);
        expect_v("rst.flush", 32'd0);
        expect_v("rst.flush_pc", 32'd0);
        expect_v("rst.status", 32'h0040_0000);
        expect_v("rst.cause", 32'd0);
        #2;
        got(32'(is_exp)); got(32'(flush)); got(flush_pc); got(status_out); got(cause_out);
        @(negedge clk);
        idle();
        resetn = 1'b1;

        for (int i = 0; i < 22; i++) apply(vecs[i]);

        // Interrupt: enable IM7/IE, raise hw_int[5] so IP7 latches.
        @(negedge clk);
        idle();
        cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_8001; hw_int = 6'b100000;
        expect_v("irq.status_wr", 32'h0040_8001);
        @(posedge clk); #1;
        got(status_out);
        @(negedge clk);
        idle();
        hw_int = 6'b100000; mem_valid = 1'b1; mem_pc = 32'h8000B000;
        expect_v("irq.is_exp", 32'd1);
        expect_v("irq.flush_pc", VEC);
        #1;
        got(32'(is_exp)); got(flush_pc);
        expect_v("irq.cause", 32'h0000_8000);
        expect_v("irq.epc", 32'h8000B000);
        expect_v("irq.status", 32'h0040_8003);
        @(posedge clk); #1;
        got(cause_out); got(epc_out); got(status_out);
        @(negedge clk);
        idle();
        hw_int = 6'b100000; mem_valid = 1'b1; mem_pc = 32'h8000C000;
        expect_v("irq_exl.is_exp", 32'd0);
        expect_v("irq_exl.flush", 32'd0);
        #1;
        got(32'(is_exp)); got(32'(flush));
        @(negedge clk);
        idle();
        mem_valid = 1'b1; mem_eret = 1'b1; mem_pc = 32'h8000C004;
        expect_v("irq_eret.flush", 32'd1);
        expect_v("irq_eret.flush_pc", 32'h8000B000);
        #1;
        got(32'(flush)); got(flush_pc);
        expect_v("irq_eret.status", 32'h0040_8001);
        expect_v("irq_eret.cause", 32'd0);
        @(posedge clk); #1;
        got(status_out); got(cause_out);

        // Mid-operation reset, then timer with Compare=5.
        @(negedge clk);
        idle();
        mem_valid = 1'b1; exc_ov = 1'b1;
        #2 resetn = 1'b0;
        expect_v("mrst.flush", 32'd0);
        expect_v("mrst.status", 32'h0040_0000);
        expect_v("mrst.epc", 32'd0);
        #1;
        got(32'(flush)); got(status_out); got(epc_out);
        @(negedge clk);
        idle();
        resetn = 1'b1;
        cp0_we = 1'b1; cp0_waddr = 5'd11; cp0_wdata = 32'd5; cp0_raddr = 5'd9;
        @(posedge clk); #1;
        cp0_we = 1'b0;
        expect_v("tmr.count_e1", 32'd0);
        got(cp0_rdata);
        repeat (8) @(posedge clk);
        #1;
        expect_v("tmr.count_e9", 32'd4);
        expect_v("tmr.cause_e9", 32'd0);
        got(cp0_rdata); got(cause_out);
        @(posedge clk); #1;
        expect_v("tmr.count_e10", 32'd5);
        expect_v("tmr.cause_ti", 32'h4000_8000);
        got(cp0_rdata); got(cause_out);
        cp0_we = 1'b1; cp0_waddr = 5'd11; cp0_wdata = 32'd9;
        @(posedge clk); #1;
        cp0_we = 1'b0;
        expect_v("tmr.ti_clear", 32'd0);
        expect_v("tmr.count_e11", 32'd5);
        got(cause_out); got(cp0_rdata);
        cp0_raddr = 5'd11;
        expect_v("tmr.compare", 32'd9);
        #1 got(cp0_rdata);
        cp0_raddr = 5'd9;
        @(posedge clk); #1;
        expect_v("tmr.count_e12", 32'd6);
        got(cp0_rdata);
        cp0_we = 1'b1; cp0_waddr = 5'd9; cp0_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        cp0_we = 1'b0;
        expect_v("tmr.count_wr", 32'hFFFF_FFFF);
        got(cp0_rdata);
        @(posedge clk); #1;
        expect_v("tmr.count_wrap", 32'd0);
        got(cp0_rdata);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
